// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-control bundle: run/stall/redirect requests in, fetch and IF/ID PCs out.
// The master modport belongs to the hazard/branch side; the slave modport belongs to pc_fetch_ctrl.
interface pc_fetch_ctrl_if #(
    parameter int PC_WIDTH   = 32,
    parameter int PERF_WIDTH = 32
);
    logic                  work_ena;
    logic                  stall;
    logic                  pc_jump;
    logic [PC_WIDTH-1:0]   pc_target;
    logic [PC_WIDTH-1:0]   pc_fetch;
    logic [PC_WIDTH-1:0]   pc_id;
    logic                  inst_valid;
    logic                  flush;
    logic [1:0]            state;
    logic [PERF_WIDTH-1:0] perf_stall_cnt;
    logic [PERF_WIDTH-1:0] perf_flush_cnt;

    modport master (
        output work_ena, stall, pc_jump, pc_target,
        input  pc_fetch, pc_id, inst_valid, flush, state,
        input  perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  work_ena, stall, pc_jump, pc_target,
        output pc_fetch, pc_id, inst_valid, flush, state,
        output perf_stall_cnt, perf_flush_cnt
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC sequencer for a 1-cycle-latency instruction BRAM.
// Optional perf counters are built when PC_FETCH_CTRL_PERF_EN is defined.
module pc_fetch_ctrl #(
    parameter int                  PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
    parameter int                  PC_STEP      = 4,
    parameter int                  FLUSH_CYCLES = 0,
    parameter int                  PERF_WIDTH   = 32
) (
    input  logic            clk,
    input  logic            rst,
    pc_fetch_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_STALL = 2'b10,
        S_FLUSH = 2'b11
    } state_e;

    localparam logic [PC_WIDTH-1:0] STEP    = PC_WIDTH'(PC_STEP);
    localparam logic [3:0]          FLUSH_N = 4'(FLUSH_CYCLES);

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_fetch_q, pc_fetch_d;
    logic [PC_WIDTH-1:0] pc_id_q, pc_id_d;
    logic                valid_q, valid_d;
    logic                flush_q, flush_d;
    logic [3:0]          cnt_q, cnt_d;

    always_comb begin
        state_d    = state_q;
        pc_fetch_d = pc_fetch_q;
        pc_id_d    = pc_id_q;
        valid_d    = valid_q;
        flush_d    = 1'b0;
        cnt_d      = cnt_q;
        if (!bus.work_ena) begin
            state_d    = S_IDLE;
            pc_fetch_d = RESET_PC;
            pc_id_d    = RESET_PC;
            valid_d    = 1'b0;
            cnt_d      = '0;
        end else if (state_q == S_IDLE) begin
            state_d = S_RUN;
        end else if (bus.pc_jump) begin
            pc_fetch_d = bus.pc_target;
            pc_id_d    = bus.pc_target;
            valid_d    = 1'b0;
            flush_d    = 1'b1;
            cnt_d      = FLUSH_N;
            state_d    = (FLUSH_N != 4'd0) ? S_FLUSH : S_RUN;
        end else if (state_q == S_FLUSH) begin
            // bubbles drain regardless of stall
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) state_d = S_RUN;
        end else if (bus.stall) begin
            state_d = S_STALL;
        end else begin
            pc_fetch_d = pc_fetch_q + STEP;
            pc_id_d    = pc_fetch_q;
            valid_d    = 1'b1;
            state_d    = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_fetch_q <= RESET_PC;
            pc_id_q    <= RESET_PC;
            valid_q    <= 1'b0;
            flush_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_fetch_q <= pc_fetch_d;
            pc_id_q    <= pc_id_d;
            valid_q    <= valid_d;
            flush_q    <= flush_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.pc_fetch   = pc_fetch_q;
    assign bus.pc_id      = pc_id_q;
    assign bus.inst_valid = valid_q;
    assign bus.flush      = flush_q;
    assign bus.state      = state_q;

`ifdef PC_FETCH_CTRL_PERF_EN
    logic [PERF_WIDTH-1:0] stall_cnt_q;
    logic [PERF_WIDTH-1:0] flush_cnt_q;
    logic                  jump_acc;

    assign jump_acc = bus.work_ena && bus.pc_jump && (state_q != S_IDLE);

    // saturating, cleared only by rst
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (state_q == S_STALL && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (jump_acc && !(&flush_cnt_q))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign bus.perf_stall_cnt = stall_cnt_q;
    assign bus.perf_flush_cnt = flush_cnt_q;
`else
    assign bus.perf_stall_cnt = '0;
    assign bus.perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench: two DUTs (FLUSH_CYCLES 0 and 2) share stimulus,
// and a reference model predicts every cycle's outputs.
module tb_pc_fetch_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_fetch_ctrl_if #(.PC_WIDTH(32), .PERF_WIDTH(32)) b0 ();
    pc_fetch_ctrl_if #(.PC_WIDTH(32), .PERF_WIDTH(32)) b2 ();

    pc_fetch_ctrl #(.FLUSH_CYCLES(0)) u0 (
        .clk(clk), .rst(rst), .bus(b0.slave)
    );
    pc_fetch_ctrl #(.FLUSH_CYCLES(2)) u2 (
        .clk(clk), .rst(rst), .bus(b2.slave)
    );

    typedef struct packed {
        logic [31:0] pcf;
        logic [31:0] pcid;
        logic        v;
        logic        fl;
        logic [1:0]  st;
        logic [31:0] ps;
        logic [31:0] pf;
    } obs_t;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] STALL = 2'b10;
    localparam logic [1:0] FLUSH = 2'b11;

    obs_t m [2];
    int   left [2];
    int   fc [2] = '{0, 2};
    obs_t q0 [$];
    obs_t q2 [$];
    int   n_tests = 0;
    int   n_fail = 0;

    function automatic void step(int k, bit r, bit we, bit st,
                                 bit j, logic [31:0] t);
        obs_t o = m[k];
        if (r) begin
            o = '0;
            left[k] = 0;
        end else begin
`ifdef PC_FETCH_CTRL_PERF_EN
            if (m[k].st == STALL && m[k].ps != 32'hFFFF_FFFF)
                o.ps = o.ps + 1;
`endif
            o.fl = 1'b0;
            if (!we) begin
                o.st = IDLE;
                o.pcf = 0;
                o.pcid = 0;
                o.v = 1'b0;
            end else if (m[k].st == IDLE) begin
                o.st = RUN;
            end else if (j) begin
`ifdef PC_FETCH_CTRL_PERF_EN
                if (m[k].pf != 32'hFFFF_FFFF) o.pf = o.pf + 1;
`endif
                o.pcf = t;
                o.pcid = t;
                o.v = 1'b0;
                o.fl = 1'b1;
                left[k] = fc[k];
                o.st = (fc[k] > 0) ? FLUSH : RUN;
            end else if (m[k].st == FLUSH) begin
                left[k] = left[k] - 1;
                if (left[k] == 0) o.st = RUN;
            end else if (st) begin
                o.st = STALL;
            end else begin
                o.pcid = m[k].pcf;
                o.pcf = m[k].pcf + 32'd4;
                o.v = 1'b1;
                o.st = RUN;
            end
        end
        m[k] = o;
    endfunction

    task automatic cyc(bit r, bit we, bit st, bit j, logic [31:0] t);
        rst = r;
        b0.work_ena = we; b0.stall = st;
        b0.pc_jump = j;   b0.pc_target = t;
        b2.work_ena = we; b2.stall = st;
        b2.pc_jump = j;   b2.pc_target = t;
        step(0, r, we, st, j, t);
        step(1, r, we, st, j, t);
        @(posedge clk);
        #1;
        q0.push_back(m[0]);
        q2.push_back(m[1]);
    endtask

    task automatic chk(string nm, obs_t a, obs_t e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s t=%0t got pcf=%h pcid=%h v=%b fl=%b st=%b ps=%0d pf=%0d required pcf=%h pcid=%h v=%b fl=%b st=%b ps=%0d pf=%0d",
                     nm, $time, a.pcf, a.pcid, a.v, a.fl, a.st, a.ps, a.pf,
                     e.pcf, e.pcid, e.v, e.fl, e.st, e.ps, e.pf);
        end
    endtask

    always @(negedge clk) begin : mon
        obs_t e;
        obs_t a;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            a = {b0.pc_fetch, b0.pc_id, b0.inst_valid, b0.flush,
                 b0.state, b0.perf_stall_cnt, b0.perf_flush_cnt};
            chk("fc0", a, e);
        end
        if (q2.size() > 0) begin
            e = q2.pop_front();
            a = {b2.pc_fetch, b2.pc_id, b2.inst_valid, b2.flush,
                 b2.state, b2.perf_stall_cnt, b2.perf_flush_cnt};
            chk("fc2", a, e);
        end
    end

    initial begin
        bit r, we, st, j;
        logic [31:0] t;
        repeat (2) cyc(1, 0, 0, 0, 0);
        repeat (5) cyc(0, 1, 0, 0, 0);
        repeat (3) cyc(0, 1, 1, 0, 0);
        repeat (2) cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 32'h100);
        repeat (4) cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 1, 32'h40);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 1, 32'h80);
        repeat (5) cyc(0, 1, 1, 0, 0);
        repeat (3) cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 32'h200);
        repeat (3) cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 32'hFFFF_FFF8);
        repeat (5) cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 500; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            we = ($urandom_range(0, 24) != 0);
            st = ($urandom_range(0, 3) == 0);
            j  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0)
                t = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            else
                t = $urandom;
            cyc(r, we, st, j, t);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (q0.size() != 0 || q2.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending, required 0/0",
                     q0.size(), q2.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
